// File: rtl/alu_core_if.sv
// alu_core_if: groups the operand/strobe inputs and the result/status outputs
// of alu_core into one bundle.
//   master: drives op/en/a/b and observes the results (stimulus side)
//   slave : receives op/en/a/b and drives the results (alu_core side)
//   op       2   00 xnor, 01 shift, 10 add, 11 mult
//   en       1   start strobe, only honoured while busy=0
//   a, b     W   operands (a[0] is the serial-in bit for shift)
//   Dout*    OW  held result buses
//   busy     1   multiply in progress
//   done     1   one-cycle pulse when a result bus updates
interface alu_core_if #(
    parameter int W  = 3,
    parameter int OW = 6
);
    logic [1:0]    op;
    logic          en;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] Doutxnor;
    logic [OW-1:0] Doutshift;
    logic [OW-1:0] Doutadd;
    logic [OW-1:0] Doutmult;
    logic          busy;
    logic          done;

    modport master (
        output op, en, a, b,
        input  Doutxnor, Doutshift, Doutadd, Doutmult, busy, done
    );

    modport slave (
        input  op, en, a, b,
        output Doutxnor, Doutshift, Doutadd, Doutmult, busy, done
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: compute stage ahead of the ALU display stage.
// On a start strobe while idle, one of four held result buses is updated:
// XNOR, shift and add finish in one cycle; multiply is a W-cycle shift-add.
// Ports:
//   clk  in  system clock, all logic on posedge
//   rst  in  synchronous active-high reset
//   bus  alu_core_if.slave: op/en/a/b in, Dout*/busy/done out
// Optional feature macro ALU_ACCUM_EN: op 10 becomes a saturating
// accumulate (Doutadd <= min(Doutadd + a + b, 2^OW-1)) instead of a+b.
module alu_core #(
    parameter int W  = 3,
    parameter int OW = 6
) (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_xnor, r_shift, r_add, r_mult;
    logic [OW-1:0] r_mcand, r_acc;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_start;
    logic [OW-1:0] w_acc_nxt;

    assign w_start = (r_state == IDLE) && bus.en;

    // Partial product including this edge's term, so the last MUL edge can
    // publish the complete product directly.
    assign w_acc_nxt = r_mplier[r_cnt] ? (r_acc + (r_mcand << r_cnt)) : r_acc;

`ifdef ALU_ACCUM_EN
    // One extra bit catches the overflow used for saturation.
    logic [OW:0] w_sum;
    assign w_sum = {1'b0, r_add} + (OW+1)'(bus.a) + (OW+1)'(bus.b);
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start && bus.op == 2'b11) w_state_nxt = MUL;
            MUL:     if (r_cnt == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xnor   <= '0;
            r_shift  <= '0;
            r_add    <= '0;
            r_mult   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                case (bus.op)
                    2'b00: begin
                        r_xnor <= {{(OW-W){1'b0}}, ~(bus.a ^ bus.b)};
                        r_done <= 1'b1;
                    end
                    2'b01: begin
                        r_shift <= {r_shift[OW-2:0], bus.a[0]};
                        r_done  <= 1'b1;
                    end
                    2'b10: begin
`ifdef ALU_ACCUM_EN
                        r_add <= w_sum[OW] ? {OW{1'b1}} : w_sum[OW-1:0];
`else
                        r_add <= OW'(bus.a) + OW'(bus.b);
`endif
                        r_done <= 1'b1;
                    end
                    default: begin
                        r_mcand  <= {{(OW-W){1'b0}}, bus.a};
                        r_mplier <= bus.b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                endcase
            end else if (r_state == MUL) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_mult <= w_acc_nxt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.Doutxnor  = r_xnor;
    assign bus.Doutshift = r_shift;
    assign bus.Doutadd   = r_add;
    assign bus.Doutmult  = r_mult;
    assign bus.busy      = (r_state == MUL);
    assign bus.done      = r_done;
endmodule
